// File: rtl/seg_serial_drv.sv
// Serial driver for shift-register 7-segment display chains: builds a hex-decoded
// or raw per-digit frame (with dp and blink) and shifts it out MSB first with a latch pulse.
module seg_serial_drv #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 2,
  parameter int BLINK_BITS   = 24,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  flash,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic [8*DIGITS-1:0]   raw,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  seg_clrn,
  output logic                  busy,
  output logic                  done
);

  localparam int F  = 8 * DIGITS;
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam int BW = $clog2(F) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(F - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;

  // Active-low {dp,g,f,e,d,c,b,a} pattern with the dp dark.
  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [F-1:0] build_frame(
    input logic m, input logic fl, input logic ph,
    input logic [4*DIGITS-1:0] hx, input logic [DIGITS-1:0] pt,
    input logic [DIGITS-1:0] le, input logic [F-1:0] rw);
    logic [F-1:0] fr;
    logic [7:0]   b;
    fr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (m) b = rw[8*i +: 8];
      else   b = hex_seg(hx[4*i +: 4]) & {~pt[i], 7'h7F};
      if (fl && le[i] && ph) b = 8'hFF;
      fr[8*i +: 8] = b;
    end
    return fr;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [F-1:0]          sh_q, sh_d;
  logic [BLINK_BITS-1:0] blink_q;
  logic                  clk_q, clk_d, pen_q, pen_d, busy_q, busy_d, done_q, done_d, clrn_q;
  logic [F-1:0]          frame_s;
  logic                  go_s;

  assign frame_s  = build_frame(mode, flash, blink_q[BLINK_BITS-1], hexs, points, les, raw);
  assign go_s     = start || (AUTO_REFRESH != 0);
  assign seg_clk  = clk_q;
  assign seg_sout = sh_q[F-1];
  assign seg_pen  = pen_q;
  assign seg_clrn = clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    clk_d   = clk_q;
    pen_d   = pen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_d  = 1'b0;
        pen_d  = 1'b1;
        busy_d = 1'b0;
        if (go_s) begin
          state_d = SHIFT;
          sh_d    = frame_s;
          cnt_d   = '0;
          bit_d   = '0;
          pen_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_LAST) begin
          clk_d = 1'b1;
        end else if (cnt_q == BIT_END) begin
          // Falling edge: either advance data or finish with the latch pulse.
          clk_d = 1'b0;
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = LATCH;
            pen_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = {sh_q[F-2:0], 1'b1};
          end
        end else begin
          clk_d = clk_q;
        end
      end
      LATCH: begin
        state_d = IDLE;
        clk_d   = 1'b0;
        pen_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        clk_d   = 1'b0;
        pen_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, shifter, blink counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '1;
      blink_q <= '0;
      clk_q   <= 1'b0;
      pen_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      blink_q <= blink_q + BLINK_BITS'(1);
      clk_q   <= clk_d;
      pen_q   <= pen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clrn_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_serial_drv.sv
// Directed bench for seg_serial_drv: table of frames plus handshake and mid-frame reset sequences.
module tb_seg_serial_drv;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, flash = 1'b0;
  logic [31:0] hexs = 32'h0;
  logic [7:0]  points = 8'h0, les = 8'h0;
  logic [63:0] raw = 64'h0;
  logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy, done;
  logic [3:0]  tb_blink;
  int          checks = 0, failures = 0;

  seg_serial_drv #(.DIGITS(8), .CLK_DIV(2), .BLINK_BITS(4), .AUTO_REFRESH(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .flash(flash), .hexs(hexs),
    .points(points), .les(les), .raw(raw), .seg_clk(seg_clk), .seg_sout(seg_sout),
    .seg_pen(seg_pen), .seg_clrn(seg_clrn), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Reference blink counter used to choose the load cycle phase.
  always @(posedge clk) begin
    if (rst) tb_blink <= 4'd0;
    else     tb_blink <= tb_blink + 4'd1;
  end

  typedef struct {
    string       name;
    logic        m;
    logic [31:0] hx;
    logic [7:0]  pt;
    logic        fl;
    logic [7:0]  le;
    logic [63:0] rw;
    logic        ph;
    logic [63:0] exp_frame;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply_inputs(input vec_t v);
    mode = v.m; hexs = v.hx; points = v.pt; flash = v.fl; les = v.le; raw = v.rw;
  endtask

  task automatic run_frame(input vec_t v, input bit pulses);
    logic [63:0] got;
    int          rises, dones, done_at, first_rise;
    logic        prev_clk;
    @(negedge clk);
    apply_inputs(v);
    for (int w = 0; w < 40 && tb_blink[3] !== v.ph; w++) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, " t0 busy/pen/clk/sout"}, {60'h0, busy, seg_pen, seg_clk, seg_sout},
        {60'h0, 1'b1, 1'b0, 1'b0, v.exp_frame[63]});
    got = 64'h0; rises = 0; dones = 0; done_at = -1; first_rise = -1; prev_clk = seg_clk;
    for (int n = 1; n <= 300; n++) begin
      if (pulses) start = (n == 10 || n == 256 || n == 257);
      if (n == 5) begin
        mode = ~mode; hexs = ~hexs; points = ~points; flash = ~flash; les = ~les; raw = ~raw;
      end
      @(posedge clk); #1;
      if (seg_clk && !prev_clk) begin
        got = {got[62:0], seg_sout};
        rises++;
        if (rises == 1) first_rise = n;
      end
      prev_clk = seg_clk;
      if (done) begin dones++; done_at = n; end
      if (n == 257) chk({v.name, " idle after latch"}, {61'h0, busy, seg_pen, seg_clk}, 64'h2);
    end
    start = 1'b0;
    chk({v.name, " frame"}, got, v.exp_frame);
    chk({v.name, " rises"}, 64'(rises), 64'd64);
    chk({v.name, " first rise"}, 64'(first_rise), 64'd2);
    chk({v.name, " done cycle"}, 64'(done_at), 64'd256);
    chk({v.name, " done count"}, 64'(dones), 64'd1);
    chk({v.name, " busy at end"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int rises, dones, d1, d2;
    logic prev_clk;
    vecs[0] = '{"hex",      1'b0, 32'h012389AF, 8'h01, 1'b0, 8'h00, 64'h0,                  1'b0, 64'hC0F9A4B08090880E};
    vecs[1] = '{"raw",      1'b1, 32'h0,        8'hFF, 1'b0, 8'h00, 64'h0123456789ABCDEF,   1'b0, 64'h0123456789ABCDEF};
    vecs[2] = '{"blink1",   1'b0, 32'h88888888, 8'h00, 1'b1, 8'h0F, 64'h0,                  1'b1, 64'h80808080FFFFFFFF};
    vecs[3] = '{"blink0",   1'b0, 32'h88888888, 8'h00, 1'b1, 8'h0F, 64'h0,                  1'b0, 64'h8080808080808080};
    vecs[4] = '{"hexdp",    1'b0, 32'h76543210, 8'hAA, 1'b0, 8'h00, 64'h0,                  1'b0, 64'h7882129930A479C0};
    vecs[5] = '{"hexhi",    1'b0, 32'hFEDCBA98, 8'h00, 1'b1, 8'hF0, 64'h0,                  1'b0, 64'h8E86A1C683889080};
    vecs[6] = '{"rawblink", 1'b1, 32'h0,        8'hFF, 1'b1, 8'h81, 64'h0011223344556677,   1'b1, 64'hFF112233445566FF};
    vecs[7] = '{"noflash",  1'b0, 32'h11111111, 8'h00, 1'b0, 8'hFF, 64'h0,                  1'b1, 64'hF9F9F9F9F9F9F9F9};

    // Reset values, then seg_clrn release.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {58'h0, seg_clk, seg_sout, seg_pen, seg_clrn, busy, done}, 64'h18);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("clrn release", {63'h0, seg_clrn}, 64'h1);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], 1'b0);

    // Start pulses while busy are dropped.
    run_frame(vecs[4], 1'b1);

    // Held start retriggers after exactly one IDLE cycle.
    @(negedge clk);
    apply_inputs(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    dones = 0; d1 = -1; d2 = -1;
    for (int n = 1; n <= 520; n++) begin
      @(posedge clk); #1;
      if (n == 258) start = 1'b0;
      if (done) begin
        dones++;
        if (d1 < 0) d1 = n; else d2 = n;
      end
      if (n == 257) chk("hold idle gap", {62'h0, busy, seg_pen}, 64'h1);
      if (n == 258) chk("hold retrigger", {62'h0, busy, seg_pen}, 64'h2);
    end
    chk("hold done1", 64'(d1), 64'd256);
    chk("hold done2", 64'(d2), 64'd514);
    chk("hold done count", 64'(dones), 64'd2);

    // Reset after the 20th rising seg_clk edge.
    @(negedge clk);
    apply_inputs(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 0; dones = 0; prev_clk = seg_clk;
    for (int n = 1; n <= 200 && rises < 20; n++) begin
      @(posedge clk); #1;
      if (seg_clk && !prev_clk) rises++;
      if (done) dones++;
      prev_clk = seg_clk;
    end
    chk("midrst rises", 64'(rises), 64'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst outputs", {58'h0, seg_pen, seg_clk, seg_clrn, busy, done, seg_sout}, 64'h21);
    chk("midrst no done", 64'(dones), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst clrn", {62'h0, seg_clrn, busy}, 64'h2);
    run_frame(vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_serial_drv.md
# seg_serial_drv

Parametrised serial driver for shift-register-based 7-segment displays. It builds a per-digit frame by one of two methods: hex decode with decimal points and per-digit blink, or raw segment pass-through. It then shifts the frame out on a clock/data/latch interface and reports busy/done, with optional continuous auto-refresh. It sits between the CPU-side display registers and the board's display shift chain.

## Interface
- DIGITS, 8, number of digits (1..16); frame width F = 8*DIGITS bits
- CLK_DIV, 2, seg_clk half-period in clk cycles (>=1)
- BLINK_BITS, 24, width of free-running blink counter (>=2)
- AUTO_REFRESH, 0, 1 = start a new frame whenever IDLE, without needing start
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  refresh request, sampled only in IDLE
- mode  in  1  0 = hex decode, 1 = raw segments
- flash  in  1  global blink enable
- hexs  in  4*DIGITS  digit i = hexs[4i+3:4i]
- points  in  DIGITS  1 = light dp of digit i (hex mode only)
- les  in  DIGITS  1 = digit i blinks when flash=1
- raw  in  F  raw segment bytes, digit i = raw[8i+7:8i]
- seg_clk  out  1  shift clock to display chain
- seg_sout  out  1  serial data
- seg_pen  out  1  latch/output enable; low while shifting, rising edge latches
- seg_clrn  out  1  active-low clear to display chain
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

## Operation
- Segment byte per digit is {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
- Hex decode for digits 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. With points[i]=1, bit7 of the byte is cleared.
- Raw mode: byte = raw digit byte unchanged; points are ignored.
- Blink: the counter is free-running and resets to 0. Phase = counter MSB. If flash=1, les[i]=1 and phase=1, byte i = FF. Blink applies in both modes.
- Frame = {byte[DIGITS-1], ..., byte[0]}, shifted MSB first.
- mode, hexs, raw, points, les, flash and phase are captured at frame load. Input changes during a frame do not affect it.
- FSM states:
  - IDLE: go to SHIFT when start=1 or AUTO_REFRESH=1. Load the shift register with the frame and set bit counter = 0.
  - SHIFT: F bits, each taking 2*CLK_DIV cycles. seg_clk is low for the first CLK_DIV cycles and high for the next CLK_DIV. seg_sout changes only on the cycle seg_clk goes low, so it is stable across the rising edge. After the high phase of bit F-1, go to LATCH.
  - LATCH: lasts 1 cycle, with seg_clk=0, seg_pen=1, done=1, busy=1. Then return to IDLE.
- seg_clrn is a registered copy of ~rst.

## Timing
- Reset values: state IDLE, seg_clk 0, seg_sout 1, seg_pen 1, seg_clrn 0, busy 0, done 0, shift register all 1s, blink counter 0.
- seg_clrn returns to 1 on the first edge with rst=0.
- If start is sampled high in IDLE at edge t0, then from t0: busy=1, seg_pen=0, seg_clk=0, seg_sout = frame bit F-1.
- Rising seg_clk edges for bit k occur at t0 + 2k*CLK_DIV + CLK_DIV.
- LATCH/done occupies cycle t0 + 2*F*CLK_DIV. IDLE with busy=0 follows one cycle later.
- With DIGITS=8 and CLK_DIV=2, done is at t0+256.
- start while busy (SHIFT or LATCH) is ignored, not queued. start held high retriggers at the first IDLE cycle, so the minimum inter-frame gap is 1 IDLE cycle. AUTO_REFRESH behaves the same way.
- rst mid-frame: reset values apply on the next edge. The partial frame is abandoned and seg_pen returns to 1 without a latch-valid frame; seg_clrn=0 clears the chain.
- The blink counter wraps modulo 2^BLINK_BITS. The phase seen by the display changes only at frame loads.

## Test plan
- Reset: assert rst for 3 cycles, then release. Required: all outputs at reset values, and seg_clrn=1 one edge after release.
- Hex frame (DIGITS=8, CLK_DIV=2): mode=0, hexs=0x012389AF, points=0x01, flash=0, pulse start. Sampling seg_sout on seg_clk rising edges must yield bytes C0 F9 A4 B0 80 90 88 0E. done must pulse at t0+256 for one cycle.
- Raw frame: mode=1, raw=0x0123456789ABCDEF, points=0xFF. The serial stream must equal raw exactly, MSB first.
- Blink (BLINK_BITS=4): flash=1, les=0x0F, hexs=0x88888888.
  - Frame loaded with phase=1 gives 80 80 80 80 FF FF FF FF.
  - Frame with phase=0 gives all bytes 80.
- Handshake: pulse start at t0+10 and t0+256. Both must be ignored, and only one done pulse occurs. Hold start high and check that the next frame begins exactly 1 cycle after LATCH.
- Mid-frame reset: assert rst after the 20th seg_clk rising edge. Required next cycle: IDLE, seg_pen=1, seg_clk=0, seg_clrn=0, busy=0, no done. A subsequent start must deliver a complete, correct 64-bit frame.
